if_fetch_buffer: RTL and testbench

IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

---
 rtl/if_fetch_buffer_if.sv | 27 ++
 rtl/if_fetch_buffer.sv | 114 +++++++++++
 tb/tb_if_fetch_buffer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_buffer_if.sv
// Fetch-buffer bundle: PC register handshake, instruction-memory request/response
// and the decode-side head-entry port.
interface if_fetch_buffer_if;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        Keep;
    logic        Flush;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Data;
    logic        ID_Ready;
    logic        ID_Valid;
    logic [31:0] ID_PC;
    logic [31:0] ID_PC4;
    logic [31:0] ID_Instr;

    modport master (
        output PC, PC4, Flush, Imem_Ack, Imem_Data, ID_Ready,
        input  Keep, Imem_Req, Imem_Addr, ID_Valid, ID_PC, ID_PC4, ID_Instr
    );

    modport slave (
        input  PC, PC4, Flush, Imem_Ack, Imem_Data, ID_Ready,
        output Keep, Imem_Req, Imem_Addr, ID_Valid, ID_PC, ID_PC4, ID_Instr
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: one outstanding memory request feeding a 2-entry
// {PC, PC4, Instr} FIFO toward decode, with flush/drop handling.
module if_fetch_buffer (
    input logic              clk,
    input logic              rst,
    if_fetch_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] req_pc4_q, req_pc4_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_pc4_q [2];
    logic [31:0] fifo_pc4_d [2];
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];

    logic issue;
    logic push;
    logic pop;

    always_comb begin
        issue = (state_q == IDLE) && (count_q < 2'd2) && !bus.Flush;
        push  = (state_q == WAIT) && bus.Imem_Ack && !bus.Flush;
        pop   = (count_q != 2'd0) && bus.ID_Ready && !bus.Flush;
    end

    // An Ack in DROP, or together with Flush in WAIT, returns to IDLE without a push.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = WAIT;
            WAIT: begin
                if (bus.Imem_Ack)   state_d = IDLE;
                else if (bus.Flush) state_d = DROP;
            end
            DROP:    if (bus.Imem_Ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_pc_d     = req_pc_q;
        req_pc4_d    = req_pc4_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_pc4_d   = fifo_pc4_q;
        fifo_instr_d = fifo_instr_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (issue) begin
            req_pc_d  = bus.PC;
            req_pc4_d = bus.PC4;
        end

        if (push) begin
            fifo_pc_d[wr_ptr_q]    = req_pc_q;
            fifo_pc4_d[wr_ptr_q]   = req_pc4_q;
            fifo_instr_d[wr_ptr_q] = bus.Imem_Data;
        end

        if (bus.Flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            req_pc_q     <= 32'h0000_0000;
            req_pc4_q    <= 32'h0000_0000;
            fifo_pc_q    <= '{32'h0000_0000, 32'h0000_0000};
            fifo_pc4_q   <= '{32'h0000_0000, 32'h0000_0000};
            fifo_instr_q <= '{32'h0000_0000, 32'h0000_0000};
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            req_pc_q     <= req_pc_d;
            req_pc4_q    <= req_pc4_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_pc4_q   <= fifo_pc4_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

    assign bus.Imem_Req  = (state_q != IDLE);
    assign bus.Imem_Addr = req_pc_q;
    assign bus.Keep      = !(issue || bus.Flush);
    assign bus.ID_Valid  = (count_q != 2'd0);
    assign bus.ID_PC     = fifo_pc_q[rd_ptr_q];
    assign bus.ID_PC4    = fifo_pc4_q[rd_ptr_q];
    assign bus.ID_Instr  = fifo_instr_q[rd_ptr_q];

    // Issue is gated on count<2, so a push can never land on a full FIFO.
    ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'd2)));
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_if_fetch_buffer;
    logic clk;
    logic rst;
    if_fetch_buffer_if bus();

    if_fetch_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    bit          m_out, m_drop;
    logic [31:0] m_rpc, m_rpc4;

    bit          p_valid, p_flush, p_pop, p_push, p_issue, p_ack;
    ent_t        p_ent;
    logic [31:0] p_pc, p_pc4;

    bit          keep_s, flush_s;

    always @(negedge clk) begin
        bit iss;
        bit vld;
        if (rst) begin
            p_valid = 1'b0;
        end else begin
            vld = (mq.size() != 0);
            iss = !m_out && (mq.size() < 2) && !bus.Flush;
            chk("keep", {31'd0, bus.Keep}, {31'd0, !(iss || bus.Flush)});
            chk("imem_req", {31'd0, bus.Imem_Req}, {31'd0, m_out});
            if (m_out) chk("imem_addr", bus.Imem_Addr, m_rpc);
            chk("id_valid", {31'd0, bus.ID_Valid}, {31'd0, vld});
            if (vld) begin
                chk("id_pc", bus.ID_PC, mq[0].pc);
                chk("id_pc4", bus.ID_PC4, mq[0].pc4);
                chk("id_instr", bus.ID_Instr, mq[0].instr);
            end
            p_valid = 1'b1;
            p_flush = bus.Flush;
            p_ack   = bus.Imem_Ack;
            p_pop   = vld && bus.ID_Ready && !bus.Flush;
            p_push  = m_out && !m_drop && bus.Imem_Ack && !bus.Flush;
            p_ent   = '{pc: m_rpc, pc4: m_rpc4, instr: bus.Imem_Data};
            p_issue = iss;
            p_pc    = bus.PC;
            p_pc4   = bus.PC4;
        end
        keep_s  = bus.Keep;
        flush_s = bus.Flush;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_out   = 1'b0;
            m_drop  = 1'b0;
            m_rpc   = 32'h0;
            m_rpc4  = 32'h0;
            p_valid = 1'b0;
        end else if (p_valid) begin
            if (p_flush) mq.delete();
            else begin
                if (p_pop) void'(mq.pop_front());
                if (p_push) mq.push_back(p_ent);
            end
            if (p_issue) begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_rpc  = p_pc;
                m_rpc4 = p_pc4;
            end else if (m_out && p_ack) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out && p_flush) begin
                m_drop = 1'b1;
            end
            p_valid = 1'b0;
        end
    end

    // ---------------- environment: PC register and memory responder ----------------
    logic [31:0] pc, flush_tgt;
    int          cnt, ack_delay;
    bit          n_ready, n_stray;

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            pc  = 32'h0;
            cnt = 0;
        end else if (!keep_s) begin
            pc = flush_s ? flush_tgt : pc + 32'd4;
        end
        bus.PC       = pc;
        bus.PC4      = pc + 32'd4;
        bus.Flush    = 1'b0;
        bus.ID_Ready = n_ready;
        if (bus.Imem_Req) cnt++;
        else cnt = 0;
        bus.Imem_Ack  = (bus.Imem_Req && (cnt >= ack_delay + 1)) || n_stray;
        bus.Imem_Data = bus.Imem_Ack ? (32'hC000_0000 | bus.Imem_Addr) : 32'hDEAD_BEEF;
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, bus.Imem_Req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.ID_Valid}, 32'd0);
        chk({tag, "_idpc"},  bus.ID_PC, 32'd0);
        chk({tag, "_idpc4"}, bus.ID_PC4, 32'd0);
        chk({tag, "_instr"}, bus.ID_Instr, 32'd0);
        chk({tag, "_addr"},  bus.Imem_Addr, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        pc = 0; flush_tgt = 0; cnt = 0; ack_delay = 0;
        n_ready = 0; n_stray = 0;
        bus.PC = 0; bus.PC4 = 4; bus.Flush = 0; bus.Imem_Ack = 0;
        bus.Imem_Data = 0; bus.ID_Ready = 0;
        step();

        // A: streaming with Ack one cycle after Req, then a 3-cycle Ack delay
        n_ready = 1; ack_delay = 0;
        do_reset();
        chk("A0_keep", {31'd0, bus.Keep}, 32'd0);
        chk("A0_req", {31'd0, bus.Imem_Req}, 32'd0);
        step();
        chk("A1_req", {31'd0, bus.Imem_Req}, 32'd1);
        chk("A1_addr", bus.Imem_Addr, 32'h0);
        chk("A1_keep", {31'd0, bus.Keep}, 32'd1);
        step();
        chk("A2_valid", {31'd0, bus.ID_Valid}, 32'd1);
        chk("A2_pc", bus.ID_PC, 32'h0);
        chk("A2_instr", bus.ID_Instr, 32'hC000_0000);
        chk("A2_keep", {31'd0, bus.Keep}, 32'd0);
        step();
        chk("A3_valid", {31'd0, bus.ID_Valid}, 32'd0);
        chk("A3_addr", bus.Imem_Addr, 32'h4);
        step();
        chk("A4_pc", bus.ID_PC, 32'h4);
        chk("A4_pc4", bus.ID_PC4, 32'h8);
        ack_delay = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("C_wait_req", {31'd0, bus.Imem_Req}, 32'd1);
            chk("C_wait_addr", bus.Imem_Addr, 32'h8);
            chk("C_wait_keep", {31'd0, bus.Keep}, 32'd1);
        end
        step();
        step();
        chk("C_valid", {31'd0, bus.ID_Valid}, 32'd1);
        chk("C_pc", bus.ID_PC, 32'h8);
        chk("C_instr", bus.ID_Instr, 32'hC000_0008);

        // B: decode stalled, FIFO fills to two, then drains in order
        n_ready = 0; ack_delay = 0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 2; i++) begin
            chk("B_full_req", {31'd0, bus.Imem_Req}, 32'd0);
            chk("B_full_keep", {31'd0, bus.Keep}, 32'd1);
            chk("B_full_pc", bus.ID_PC, 32'h0);
            step();
        end
        n_ready = 1;
        step();
        chk("B_pop0_pc", bus.ID_PC, 32'h0);
        chk("B_pop0_keep", {31'd0, bus.Keep}, 32'd1);
        step();
        chk("B_pop1_pc", bus.ID_PC, 32'h4);
        chk("B_pop1_keep", {31'd0, bus.Keep}, 32'd0);
        step();
        chk("B_empty_valid", {31'd0, bus.ID_Valid}, 32'd0);
        chk("B_next_addr", bus.Imem_Addr, 32'h8);

        // D: Flush while waiting, Ack two cycles later is dropped
        n_ready = 1; ack_delay = 2;
        do_reset();
        step();
        chk("D1_addr", bus.Imem_Addr, 32'h0);
        bus.Flush = 1'b1; flush_tgt = 32'h100;
        #1;
        chk("D1_keep", {31'd0, bus.Keep}, 32'd0);
        step();
        chk("D2_req", {31'd0, bus.Imem_Req}, 32'd1);
        chk("D2_keep", {31'd0, bus.Keep}, 32'd1);
        step();
        chk("D3_req", {31'd0, bus.Imem_Req}, 32'd1);
        chk("D3_valid", {31'd0, bus.ID_Valid}, 32'd0);
        step();
        chk("D4_valid", {31'd0, bus.ID_Valid}, 32'd0);
        chk("D4_keep", {31'd0, bus.Keep}, 32'd0);
        ack_delay = 0;
        step();
        chk("D5_addr", bus.Imem_Addr, 32'h100);
        step();
        chk("D6_pc", bus.ID_PC, 32'h100);
        chk("D6_instr", bus.ID_Instr, 32'hC000_0100);

        // E: Flush with a full FIFO and a stray Ack, then Flush together with a real Ack
        n_ready = 0; ack_delay = 0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        bus.Flush = 1'b1; bus.Imem_Ack = 1'b1; bus.Imem_Data = 32'h0BAD_0BAD;
        flush_tgt = 32'h200;
        #1;
        chk("E4_keep", {31'd0, bus.Keep}, 32'd0);
        step();
        chk("E5_valid", {31'd0, bus.ID_Valid}, 32'd0);
        chk("E5_keep", {31'd0, bus.Keep}, 32'd0);
        step();
        chk("E6_addr", bus.Imem_Addr, 32'h200);
        bus.Flush = 1'b1; flush_tgt = 32'h300;
        #1;
        chk("E6_keep", {31'd0, bus.Keep}, 32'd0);
        step();
        chk("E7_valid", {31'd0, bus.ID_Valid}, 32'd0);
        chk("E7_req", {31'd0, bus.Imem_Req}, 32'd0);
        step();
        chk("E8_addr", bus.Imem_Addr, 32'h300);
        step();
        chk("E9_pc", bus.ID_PC, 32'h300);
        chk("E9_pc4", bus.ID_PC4, 32'h304);
        chk("E9_instr", bus.ID_Instr, 32'hC000_0300);

        // F: asynchronous reset mid-request, stray Ack after release ignored
        n_ready = 0; ack_delay = 0;
        do_reset();
        step();
        step();
        ack_delay = 10;
        step();
        chk("F3_valid", {31'd0, bus.ID_Valid}, 32'd1);
        chk("F3_addr", bus.Imem_Addr, 32'h4);
        rst = 1'b1;
        #1;
        chk_reset_outputs("F_async");
        ack_delay = 0; n_stray = 1;
        step();
        rst = 1'b0;
        #1;
        n_stray = 0;
        chk("F0_keep", {31'd0, bus.Keep}, 32'd0);
        step();
        chk("F1_req", {31'd0, bus.Imem_Req}, 32'd1);
        chk("F1_addr", bus.Imem_Addr, 32'h0);
        chk("F1_valid", {31'd0, bus.ID_Valid}, 32'd0);
        step();
        chk("F2_pc", bus.ID_PC, 32'h0);
        chk("F2_instr", bus.ID_Instr, 32'hC000_0000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
